// File: rtl/jump_motion_ctl.sv
// jump_motion_ctl: two-axis tick-driven player motion (walk, charge, ballistic jump, ceiling/walls).
// Latency: outputs are registered and change one clk after the deciding edge; motion steps only on ticks.
// Backpressure: none; keys are sampled as levels every clk and the draw stage consumes value_x/value_y directly.
//
// Ports: clk, rst (sync, active-high); key_space/key_left/key_right (level keys);
//        value_x/value_y (player left/top edge), state_o (GROUND=0, CHARGE=1, AIR=2, LAND=3),
//        charge_o (charge count), on_ground (high outside AIR).
// Option: define JUMP_WALL_BOUNCE_EN to reflect vx off side walls scaled by BOUNCE_NUM/BOUNCE_DEN;
//         otherwise a wall hit zeroes vx and the player slides down the wall.
module jump_motion_ctl #(
   parameter int POS_W           = 12,
   parameter int SCREEN_WIDTH    = 800,
   parameter int SCREEN_HEIGHT   = 600,
   parameter int RECT_WIDTH      = 48,
   parameter int RECT_HEIGHT     = 64,
   parameter int X_START         = 0,
   parameter int CLOCKS_PER_TICK = 1_000_000,
   parameter int GRAVITY         = 1,
   parameter int MAX_FALL        = 24,
   parameter int WALK_SPEED      = 2,
   parameter int JUMP_VY_BASE    = 4,
   parameter int MAX_CHARGE      = 32,
   parameter int BOUNCE_NUM      = 3,
   parameter int BOUNCE_DEN      = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             key_space,
   input  logic                             key_left,
   input  logic                             key_right,
   output logic [POS_W-1:0]                 value_x,
   output logic [POS_W-1:0]                 value_y,
   output logic [1:0]                       state_o,
   output logic [$clog2(MAX_CHARGE+1)-1:0]  charge_o,
   output logic                             on_ground
);

   localparam int VW      = POS_W + 1;  // signed velocity width
   localparam int CAW     = POS_W + 2;  // signed candidate-position width
   localparam int CW      = $clog2(MAX_CHARGE + 1);
   localparam int TW      = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
   localparam int FLOOR_Y = SCREEN_HEIGHT - RECT_HEIGHT - 1;
   localparam int X_MAX   = SCREEN_WIDTH - RECT_WIDTH;

   localparam logic signed [CAW-1:0] ZERO_C  = '0;
   localparam logic signed [CAW-1:0] FLOOR_C = CAW'(FLOOR_Y);
   localparam logic signed [CAW-1:0] XMAX_C  = CAW'(X_MAX);
   localparam logic signed [CAW-1:0] WALK_C  = CAW'(WALK_SPEED);
   localparam logic signed [VW-1:0]  GRAV_V  = VW'(GRAVITY);
   localparam logic signed [VW-1:0]  MAXF_V  = VW'(MAX_FALL);
   localparam logic signed [VW-1:0]  BASE_V  = VW'(JUMP_VY_BASE);
   localparam logic signed [VW-1:0]  ONE_V   = VW'(1);
   localparam logic [CW-1:0]         MAXC_C  = CW'(MAX_CHARGE);
   localparam logic [TW-1:0]         TMAX_C  = TW'(CLOCKS_PER_TICK - 1);

   typedef enum logic [1:0] {
      S_GROUND = 2'd0,
      S_CHARGE = 2'd1,
      S_AIR    = 2'd2,
      S_LAND   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [POS_W-1:0]       x_q, x_d, y_q, y_d;
   logic signed [VW-1:0]   vx_q, vx_d, vy_q, vy_d;
   logic [CW-1:0]          charge_q, charge_d;
   logic [TW-1:0]          cnt_q;
   logic                   space_prev_q;

   logic                   tick;
   logic                   space_rise;
   logic signed [CAW-1:0]  x_ext, y_ext, nx, ny, walk_l, walk_r;
   logic signed [VW-1:0]   vy_grav, vy_fall;
   logic [CW-1:0]          charge_inc, launch_chg;
   logic signed [VW-1:0]   chg_ext, launch_vy, launch_mag, launch_vx;
   logic signed [VW-1:0]   wall_vx;

   assign tick       = (cnt_q == TMAX_C);
   assign space_rise = key_space & ~space_prev_q;

   // Candidates in a two-bit-wider signed domain so underflow and overshoot are visible before clamping.
   assign x_ext  = $signed({2'b00, x_q});
   assign y_ext  = $signed({2'b00, y_q});
   assign nx     = x_ext + CAW'(vx_q);
   assign ny     = y_ext + CAW'(vy_q);
   assign walk_l = x_ext - WALK_C;
   assign walk_r = x_ext + WALK_C;

   assign vy_grav = vy_q + GRAV_V;
   assign vy_fall = (vy_grav > MAXF_V) ? MAXF_V : vy_grav;

   assign charge_inc = (charge_q >= MAXC_C) ? MAXC_C : charge_q + CW'(1);

   // A launch while space is still held can only be the auto-jump, which always uses full charge;
   // a release launches with whatever has been accumulated so far.
   assign launch_chg = key_space ? MAXC_C : charge_q;
   assign chg_ext    = $signed({{(VW-CW){1'b0}}, launch_chg});
   assign launch_vy  = -(BASE_V + (chg_ext >>> 1));
   assign launch_mag = (chg_ext >>> 2) + ONE_V;
   assign launch_vx  = (key_right & ~key_left) ?  launch_mag :
                       (key_left & ~key_right) ? -launch_mag : '0;

`ifdef JUMP_WALL_BOUNCE_EN
   logic signed [31:0] bounce_prod, bounce_quot;
   assign bounce_prod = 32'(vx_q) * BOUNCE_NUM;
   // Signed division truncates toward zero, so small speeds decay to 0 rather than to -1.
   assign bounce_quot = (-bounce_prod) / BOUNCE_DEN;
   assign wall_vx     = VW'(bounce_quot);
`else
   assign wall_vx     = '0;
`endif

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vx_d     = vx_q;
      vy_d     = vy_q;
      charge_d = charge_q;
      case (state_q)
         S_GROUND: begin
            if (space_rise) begin
               state_d  = S_CHARGE;
               charge_d = '0;
            end else if (tick) begin
               if (key_left & ~key_right)
                  x_d = (walk_l < ZERO_C) ? '0 : POS_W'(walk_l);
               else if (key_right & ~key_left)
                  x_d = (walk_r > XMAX_C) ? POS_W'(X_MAX) : POS_W'(walk_r);
            end
         end
         S_CHARGE: begin
            if (!key_space || (tick && charge_inc == MAXC_C)) begin
               state_d  = S_AIR;
               charge_d = '0;
               vx_d     = launch_vx;
               vy_d     = launch_vy;
            end else if (tick) begin
               charge_d = charge_inc;
            end
         end
         S_AIR: begin
            if (tick) begin
               if (nx < ZERO_C) begin
                  x_d  = '0;
                  vx_d = wall_vx;
               end else if (nx > XMAX_C) begin
                  x_d  = POS_W'(X_MAX);
                  vx_d = wall_vx;
               end else begin
                  x_d  = POS_W'(nx);
               end
               // Vertical outcome is decided after x so a floor contact overrides any wall vx.
               if (ny < ZERO_C) begin
                  y_d  = '0;
                  vy_d = '0;
               end else if (ny >= FLOOR_C) begin
                  y_d     = POS_W'(FLOOR_Y);
                  vx_d    = '0;
                  vy_d    = '0;
                  state_d = S_LAND;
               end else begin
                  y_d  = POS_W'(ny);
                  vy_d = vy_fall;
               end
            end
         end
         S_LAND: begin
            if (tick)
               state_d = S_GROUND;
         end
         default: state_d = S_GROUND;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_GROUND;
         x_q          <= POS_W'(X_START);
         y_q          <= POS_W'(FLOOR_Y);
         vx_q         <= '0;
         vy_q         <= '0;
         charge_q     <= '0;
         cnt_q        <= '0;
         space_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         vx_q         <= vx_d;
         vy_q         <= vy_d;
         charge_q     <= charge_d;
         cnt_q        <= tick ? '0 : cnt_q + TW'(1);
         space_prev_q <= key_space;
      end
   end

   assign value_x   = x_q;
   assign value_y   = y_q;
   assign state_o   = state_q;
   assign charge_o  = charge_q;
   assign on_ground = (state_q != S_AIR);

endmodule
